ball_possession_arbiter: RTL and testbench

- Decides which glove, if any, owns the ball. Generates the physics update tick and arbitrates catches when both gloves contend. Enforces a release cooldown so a throwing glove cannot instantly re-catch.
- Sits between the glove tracking front end and the ball physics/position block.
- Drives `owner` to select whether ball position follows glove1, glove2 or free flight.

---
 rtl/ball_possession_arbiter.sv | 159 +++++++++++++++
 tb/tb_ball_possession_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_possession_arbiter.sv
// Ball possession arbiter: update-tick generator, two-glove catch arbitration
// and a post-release cooldown that keeps the throwing glove from re-catching.
module ball_possession_arbiter #(
  parameter int TICK_DIV       = 225000,
  parameter int CATCH_RADIUS   = 150,
  parameter int COOLDOWN_TICKS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] glove1x,
  input  logic [15:0] glove1y,
  input  logic [15:0] glove2x,
  input  logic [15:0] glove2y,
  input  logic        glove1closed,
  input  logic        glove2closed,
  input  logic [15:0] ballx,
  input  logic [15:0] bally,
  output logic        tick,
  output logic [1:0]  owner,
  output logic        catch_pulse,
  output logic        release_pulse,
  output logic [1:0]  release_glove
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int CD_W  = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TICK_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(COOLDOWN_TICKS);
  localparam logic [CD_W-1:0]  CD_ONE   = CD_W'(1);
  localparam logic [16:0]      RADIUS   = 17'(CATCH_RADIUS);

  typedef enum logic [1:0] {
    AIR   = 2'd0,
    HELD1 = 2'd1,
    HELD2 = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             tick_reg;
  logic             catch_reg, catch_next;
  logic             release_reg, release_next;
  logic [1:0]       release_glove_reg, release_glove_next;
  logic [CD_W-1:0]  cooldown_reg, cooldown_next;
  logic [1:0]       prev_closed_reg, prev_closed_next;

  logic [15:0] glove_x [2];
  logic [15:0] glove_y [2];
  logic [1:0]  closed;
  logic [1:0]  eligible;

  assign glove_x[0] = glove1x;
  assign glove_y[0] = glove1y;
  assign glove_x[1] = glove2x;
  assign glove_y[1] = glove2y;
  assign closed     = {glove2closed, glove1closed};

  // tick is registered one cycle early so it is high exactly while cnt_reg == TICK_DIV-1
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_ONE;
      tick_reg <= (cnt_reg == CNT_PRE);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_glove
      localparam logic [1:0] GLOVE_ID = 2'(gi + 1);
      logic [16:0] dist_x, dist_y;
      logic        near, newly_closed, blocked;

      // 17-bit magnitudes so coordinates near 0 and 65535 never alias
      assign dist_x = (glove_x[gi] >= ballx) ? ({1'b0, glove_x[gi]} - {1'b0, ballx})
                                             : ({1'b0, ballx} - {1'b0, glove_x[gi]});
      assign dist_y = (glove_y[gi] >= bally) ? ({1'b0, glove_y[gi]} - {1'b0, bally})
                                             : ({1'b0, bally} - {1'b0, glove_y[gi]});
      assign near         = (dist_x <= RADIUS) && (dist_y <= RADIUS);
      assign newly_closed = closed[gi] & ~prev_closed_reg[gi];
      assign blocked      = (release_glove_reg == GLOVE_ID) && (cooldown_reg != '0);
      assign eligible[gi] = newly_closed & near & ~blocked;
    end
  endgenerate

  always_comb begin
    state_next         = state_reg;
    catch_next         = 1'b0;
    release_next       = 1'b0;
    release_glove_next = release_glove_reg;
    cooldown_next      = cooldown_reg;
    prev_closed_next   = prev_closed_reg;
    if (tick_reg) begin
      prev_closed_next = closed;
      if (cooldown_reg != '0) cooldown_next = cooldown_reg - CD_ONE;
      case (state_reg)
        AIR: begin
          if (eligible == 2'b11) begin
            // contention goes to the glove that did not throw last
            state_next = (release_glove_reg == 2'd1) ? HELD2 : HELD1;
            catch_next = 1'b1;
          end else if (eligible[0]) begin
            state_next = HELD1;
            catch_next = 1'b1;
          end else if (eligible[1]) begin
            state_next = HELD2;
            catch_next = 1'b1;
          end
        end
        HELD1: begin
          if (!glove1closed) begin
            state_next         = AIR;
            release_next       = 1'b1;
            release_glove_next = 2'd1;
            cooldown_next      = CD_INIT;
          end
        end
        HELD2: begin
          if (!glove2closed) begin
            state_next         = AIR;
            release_next       = 1'b1;
            release_glove_next = 2'd2;
            cooldown_next      = CD_INIT;
          end
        end
        default: state_next = AIR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= AIR;
      catch_reg         <= 1'b0;
      release_reg       <= 1'b0;
      release_glove_reg <= 2'd0;
      cooldown_reg      <= '0;
      prev_closed_reg   <= 2'b00;
    end else begin
      state_reg         <= state_next;
      catch_reg         <= catch_next;
      release_reg       <= release_next;
      release_glove_reg <= release_glove_next;
      cooldown_reg      <= cooldown_next;
      prev_closed_reg   <= prev_closed_next;
    end
  end

  assign tick          = tick_reg;
  assign owner         = state_reg;
  assign catch_pulse   = catch_reg;
  assign release_pulse = release_reg;
  assign release_glove = release_glove_reg;

endmodule

// File: tb/tb_ball_possession_arbiter.sv
// Bench for ball_possession_arbiter: directed scenarios with fixed expectations,
// then random stimulus against a tick-indexed behavioural model.
module tb_ball_possession_arbiter;

  localparam int TICK_DIV       = 4;
  localparam int CATCH_RADIUS   = 150;
  localparam int COOLDOWN_TICKS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] glove1x, glove1y, glove2x, glove2y, ballx, bally;
  logic        glove1closed, glove2closed;
  logic        tick, catch_pulse, release_pulse;
  logic [1:0]  owner, release_glove;

  int n_vec = 0;
  int n_err = 0;

  // model state: cycles since reset, tick index, tick index of last release
  int m_cyc, m_tickno, m_reltick, m_owner, m_rg;
  bit m_catch, m_rel, m_prev1, m_prev2, m_decided;

  ball_possession_arbiter #(
    .TICK_DIV(TICK_DIV), .CATCH_RADIUS(CATCH_RADIUS), .COOLDOWN_TICKS(COOLDOWN_TICKS)
  ) dut (
    .clk(clk), .reset(reset),
    .glove1x(glove1x), .glove1y(glove1y), .glove2x(glove2x), .glove2y(glove2y),
    .glove1closed(glove1closed), .glove2closed(glove2closed),
    .ballx(ballx), .bally(bally),
    .tick(tick), .owner(owner), .catch_pulse(catch_pulse),
    .release_pulse(release_pulse), .release_glove(release_glove)
  );

  always #5 clk = ~clk;

  function automatic bit near(input logic [15:0] gx, input logic [15:0] gy);
    int dx, dy;
    dx = int'(gx) - int'(ballx);
    dy = int'(gy) - int'(bally);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx <= CATCH_RADIUS) && (dy <= CATCH_RADIUS);
  endfunction

  function automatic logic [15:0] jitter(input logic [15:0] c);
    int v;
    v = int'(c) + int'($urandom_range(0, 440)) - 220;
    if (v < 0) v = 0;
    if (v > 65535) v = 65535;
    return 16'(v);
  endfunction

  // advance one clock; model consumes the inputs present at the edge
  task automatic step();
    bit e1, e2;
    @(posedge clk);
    m_decided = 0;
    if (reset) begin
      m_cyc = 0; m_tickno = 0; m_reltick = -1000; m_owner = 0; m_rg = 0;
      m_catch = 0; m_rel = 0; m_prev1 = 0; m_prev2 = 0;
    end else begin
      m_catch = 0;
      m_rel   = 0;
      if (m_cyc % TICK_DIV == TICK_DIV - 1) begin
        m_decided = 1;
        m_tickno++;
        e1 = glove1closed && !m_prev1 && near(glove1x, glove1y) &&
             !(m_rg == 1 && m_tickno - m_reltick <= COOLDOWN_TICKS);
        e2 = glove2closed && !m_prev2 && near(glove2x, glove2y) &&
             !(m_rg == 2 && m_tickno - m_reltick <= COOLDOWN_TICKS);
        if (m_owner == 0) begin
          if (e1 && e2) begin m_owner = (m_rg == 1) ? 2 : 1; m_catch = 1; end
          else if (e1)  begin m_owner = 1; m_catch = 1; end
          else if (e2)  begin m_owner = 2; m_catch = 1; end
        end else if ((m_owner == 1 && !glove1closed) || (m_owner == 2 && !glove2closed)) begin
          m_rel = 1; m_rg = m_owner; m_reltick = m_tickno; m_owner = 0;
        end
        m_prev1 = glove1closed;
        m_prev2 = glove2closed;
      end
      m_cyc++;
    end
    #1;
  endtask

  task automatic next_tick();
    for (int i = 0; i < TICK_DIV + 1; i++) begin
      step();
      if (m_decided) break;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic attempt_catch1(input logic [15:0] x, input logic [15:0] y);
    do_reset();
    glove1x = x; glove1y = y; glove1closed = 1'b0;
    glove2x = 16'd20000; glove2y = 16'd20000; glove2closed = 1'b0;
    next_tick();
    glove1closed = 1'b1;
    next_tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    n_vec++;
    if ({tick, owner, catch_pulse, release_pulse, release_glove} !== 7'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 0000000",
                        {tick, owner, catch_pulse, release_pulse, release_glove});
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_vec++;
      if (tick !== 1'((c % TICK_DIV) == 3)) begin
        n_err++; $display("FAIL tick_cycle%0d: got %b expected %b", c, tick, (c % TICK_DIV) == 3);
      end
      if (c < TICK_DIV) begin
        n_vec++;
        if ({owner, catch_pulse, release_pulse, release_glove} !== 6'b0) begin
          n_err++; $display("FAIL pre_tick_outputs_cycle%0d: got %b expected 000000", c,
                            {owner, catch_pulse, release_pulse, release_glove});
        end
      end
      step();
    end
    $display("test_reset: tick pattern checked over 12 cycles");
  endtask

  task automatic test_catch_radius();
    ballx = 16'd1000; bally = 16'd1000;
    attempt_catch1(16'd1100, 16'd950);
    n_vec++;
    if (owner !== 2'd1 || catch_pulse !== 1'b1) begin
      n_err++; $display("FAIL catch_in_radius: got owner=%0d catch=%b expected owner=1 catch=1", owner, catch_pulse);
    end
    step();
    n_vec++;
    if (owner !== 2'd1 || catch_pulse !== 1'b0) begin
      n_err++; $display("FAIL catch_pulse_width: got owner=%0d catch=%b expected owner=1 catch=0", owner, catch_pulse);
    end
    attempt_catch1(16'd1151, 16'd1000);
    n_vec++;
    if (owner !== 2'd0 || catch_pulse !== 1'b0) begin
      n_err++; $display("FAIL catch_x_151: got owner=%0d catch=%b expected owner=0 catch=0", owner, catch_pulse);
    end
    attempt_catch1(16'd850, 16'd1150);
    n_vec++;
    if (owner !== 2'd1) begin
      n_err++; $display("FAIL catch_edge_150: got owner=%0d expected 1", owner);
    end
    ballx = 16'd50; bally = 16'd50;
    attempt_catch1(16'd65500, 16'd50);
    n_vec++;
    if (owner !== 2'd0) begin
      n_err++; $display("FAIL catch_no_wrap: got owner=%0d expected 0", owner);
    end
    $display("test_catch_radius: inside, x+151, corner 150, wrap-around cases applied");
  endtask

  task automatic test_cooldown();
    ballx = 16'd1000; bally = 16'd1000;
    attempt_catch1(16'd1100, 16'd950);
    glove1closed = 1'b0;
    next_tick();
    n_vec++;
    if (owner !== 2'd0 || release_pulse !== 1'b1 || release_glove !== 2'd1) begin
      n_err++; $display("FAIL release: got owner=%0d rel=%b rg=%0d expected owner=0 rel=1 rg=1",
                        owner, release_pulse, release_glove);
    end
    step();
    n_vec++;
    if (release_pulse !== 1'b0) begin
      n_err++; $display("FAIL release_pulse_width: got %b expected 0", release_pulse);
    end
    next_tick();                     // cooldown tick 1, glove open
    glove1closed = 1'b1;
    next_tick();                     // cooldown tick 2, new edge but blocked
    n_vec++;
    if (owner !== 2'd0 || catch_pulse !== 1'b0) begin
      n_err++; $display("FAIL cooldown_block: got owner=%0d catch=%b expected owner=0 catch=0", owner, catch_pulse);
    end
    glove1closed = 1'b0;
    next_tick();                     // cooldown tick 3
    glove1closed = 1'b1;
    next_tick();                     // tick 4 after release: allowed
    n_vec++;
    if (owner !== 2'd1 || catch_pulse !== 1'b1) begin
      n_err++; $display("FAIL cooldown_expired: got owner=%0d catch=%b expected owner=1 catch=1", owner, catch_pulse);
    end
    $display("test_cooldown: release then blocked/allowed re-catch applied");
  endtask

  task automatic test_both();
    ballx = 16'd1000; bally = 16'd1000;
    do_reset();
    glove1x = 16'd1100; glove1y = 16'd950;  glove1closed = 1'b0;
    glove2x = 16'd900;  glove2y = 16'd1050; glove2closed = 1'b0;
    next_tick();
    glove1closed = 1'b1; glove2closed = 1'b1;
    next_tick();
    n_vec++;
    if (owner !== 2'd1 || catch_pulse !== 1'b1) begin
      n_err++; $display("FAIL both_rg0: got owner=%0d catch=%b expected owner=1 catch=1", owner, catch_pulse);
    end
    glove1closed = 1'b0; glove2closed = 1'b0;
    next_tick();
    n_vec++;
    if (release_glove !== 2'd1) begin
      n_err++; $display("FAIL both_release_g1: got rg=%0d expected 1", release_glove);
    end
    for (int i = 0; i < COOLDOWN_TICKS; i++) next_tick();
    glove1closed = 1'b1; glove2closed = 1'b1;
    next_tick();
    n_vec++;
    if (owner !== 2'd2 || catch_pulse !== 1'b1) begin
      n_err++; $display("FAIL both_rg1: got owner=%0d catch=%b expected owner=2 catch=1", owner, catch_pulse);
    end
    $display("test_both: simultaneous catches with rg=0 and rg=1 applied");
  endtask

  task automatic test_no_steal();
    // continues from test_both: glove2 owns the ball
    glove1closed = 1'b0;
    next_tick();
    glove1closed = 1'b1;
    next_tick();
    n_vec++;
    if (owner !== 2'd2 || catch_pulse !== 1'b0) begin
      n_err++; $display("FAIL no_steal: got owner=%0d catch=%b expected owner=2 catch=0", owner, catch_pulse);
    end
    glove2closed = 1'b0;
    next_tick();
    n_vec++;
    if (owner !== 2'd0 || release_pulse !== 1'b1 || release_glove !== 2'd2) begin
      n_err++; $display("FAIL release_g2: got owner=%0d rel=%b rg=%0d expected owner=0 rel=1 rg=2",
                        owner, release_pulse, release_glove);
    end
    $display("test_no_steal: glove1 edge ignored while glove2 holds");
  endtask

  task automatic test_hold_no_edge();
    ballx = 16'd1000; bally = 16'd1000;
    do_reset();
    glove2x = 16'd20000; glove2y = 16'd20000; glove2closed = 1'b0;
    glove1x = 16'd5000;  glove1y = 16'd5000;  glove1closed = 1'b1;
    next_tick();
    glove1x = 16'd1000; glove1y = 16'd1000;
    next_tick();
    next_tick();
    n_vec++;
    if (owner !== 2'd0) begin
      n_err++; $display("FAIL hold_no_edge: got owner=%0d expected 0", owner);
    end
    $display("test_hold_no_edge: closed glove moved onto ball");
  endtask

  task automatic test_reset_mid_hold();
    ballx = 16'd1000; bally = 16'd1000;
    attempt_catch1(16'd1100, 16'd950);
    step();
    glove1closed = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if (owner !== 2'd0 || release_pulse !== 1'b0 || tick !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_hold: got owner=%0d rel=%b tick=%b expected 0 0 0", owner, release_pulse, tick);
    end
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (tick !== 1'(c == 3) || release_pulse !== 1'b0) begin
        n_err++; $display("FAIL reset_restart_cycle%0d: got tick=%b rel=%b expected tick=%b rel=0",
                          c, tick, release_pulse, c == 3);
      end
      step();
    end
    $display("test_reset_mid_hold: reset while held, counter restart checked");
  endtask

  task automatic test_random();
    ballx = 16'($urandom_range(0, 65535)); bally = 16'($urandom_range(0, 65535));
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        ballx = 16'($urandom_range(0, 65535)); bally = 16'($urandom_range(0, 65535));
      end
      if ($urandom_range(0, 7) == 0) begin
        glove1x = jitter(ballx); glove1y = jitter(bally);
        if ($urandom_range(0, 7) == 0) glove1x = 16'($urandom_range(0, 65535));
      end
      if ($urandom_range(0, 7) == 0) begin
        glove2x = jitter(ballx); glove2y = jitter(bally);
        if ($urandom_range(0, 7) == 0) glove2y = 16'($urandom_range(0, 65535));
      end
      if ($urandom_range(0, 5) == 0) glove1closed = ~glove1closed;
      if ($urandom_range(0, 5) == 0) glove2closed = ~glove2closed;
      reset = ($urandom_range(0, 399) == 0);
      step();
      n_vec++;
      if (tick !== 1'(m_cyc % TICK_DIV == TICK_DIV - 1) || owner !== 2'(m_owner) ||
          catch_pulse !== m_catch || release_pulse !== m_rel || release_glove !== 2'(m_rg)) begin
        n_err++;
        if (n_err < 20)
          $display("FAIL rand_cycle%0d: got tick=%b owner=%0d catch=%b rel=%b rg=%0d expected tick=%b owner=%0d catch=%b rel=%b rg=%0d",
                   i, tick, owner, catch_pulse, release_pulse, release_glove,
                   m_cyc % TICK_DIV == TICK_DIV - 1, m_owner, m_catch, m_rel, m_rg);
      end
      if (m_catch) $display("rand %0d: catch by glove%0d", i, m_owner);
      if (m_rel)   $display("rand %0d: release by glove%0d", i, m_rg);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    glove1x = '0; glove1y = '0; glove2x = '0; glove2y = '0;
    ballx = '0; bally = '0;
    glove1closed = 1'b0; glove2closed = 1'b0;
    m_cyc = 0; m_tickno = 0; m_reltick = -1000; m_owner = 0; m_rg = 0;
    m_catch = 0; m_rel = 0; m_prev1 = 0; m_prev2 = 0; m_decided = 0;
    test_reset();
    test_catch_radius();
    test_cooldown();
    test_both();
    test_no_steal();
    test_hold_no_edge();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
